// File: rtl/note_uart_tx_if.sv
// Note-byte handshake between a note source (key scanner, sequencer) and the UART transmitter.
// The source drives valid/code and the transmitter returns ready.
interface note_uart_tx_if;
    logic       note_valid;
    logic [7:0] note_code;
    logic       note_ready;

    modport master (output note_valid, output note_code, input note_ready);
    modport slave  (input note_valid, input note_code, output note_ready);
endinterface

// File: rtl/note_uart_tx.sv
// 8N1 UART transmitter for the piano note link, fed by a small note FIFO.
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) on the line
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into the next START if a byte is queued
module note_uart_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    note_uart_tx_if.slave note,
    output logic          TxD,
    output logic          busy,
    output logic [4:0]    fifo_count,
    output logic          overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [4:0]    DEPTH_C   = 5'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    logic          overflow_q;
    logic          ready, push, drop, load, baud_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            overflow_q <= drop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset; discarding is done by clearing the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= note.note_code;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (!baud_done) begin
                    baud_d = baud_q + 1'b1;
                end else if (bit_q == 3'd7) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                    bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (!baud_done) begin
                    baud_d = baud_q + 1'b1;
                end else if (load) begin
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        baud_done = (baud_q == BAUD_LAST);
        load      = (count_q != 5'd0) &&
                    ((state_q == IDLE) || ((state_q == STOP) && baud_done));
        ready     = (count_q != DEPTH_C);
    end

    // Readiness comes from the pre-edge count, so a same-edge pop never rescues a write to a full FIFO.
    always_comb begin
        push    = note.note_valid && ready;
        drop    = note.note_valid && !ready;
        count_d = count_q;
        if (push && !load)      count_d = count_q + 5'd1;
        else if (!push && load) count_d = count_q - 5'd1;
    end

    assign note.note_ready = ready;
    assign TxD             = tx_q;
    assign fifo_count      = count_q;
    assign overflow        = overflow_q;
endmodule

// File: doc/note_uart_tx.md
# note_uart_tx

UART 8N1 transmitter for the piano's note link. It accepts note-code bytes from a local source such as the key scanner or the sequencer, holds them in a small FIFO, and serializes them LSB-first on `TxD`. The 8N1 framing matches what the piano's UART receiver expects. It sits at the sending end of the serial link that drives the piano top level.

## Interface
- `CLKS_PER_BIT`, 10417, clock cycles per serial bit (100 MHz / 9600 baud); must be ≥ 2.
- `FIFO_DEPTH`, 8, note FIFO entries; power of two, 2–16.
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `note_valid`  in  1  source offers `note_code` this cycle.
- `note_code`  in  8  byte to send (piano codes are 2–11; any value is transmitted unchanged).
- `note_ready`  out  1  FIFO can accept; combinational, equals `fifo_count != FIFO_DEPTH`.
- `TxD`  out  1  serial line, idle high; registered.
- `busy`  out  1  high while a frame is on the line (START, DATA or STOP).
- `fifo_count`  out  5  entries currently held, 0..`FIFO_DEPTH`.
- `overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- Reset values:
  - `TxD`=1, `busy`=0, `fifo_count`=0, `overflow`=0.
  - FIFO pointers 0; state IDLE; bit counter and baud counter 0.
  - `note_ready`=1 after reset.
- Push: on a clock edge with `note_valid`=1 and `note_ready`=1, `note_code` is written at the write pointer.
- Drop: if `note_valid`=1 while `note_ready`=0, the byte is dropped and `overflow` pulses for exactly one cycle.
  - A pop in the same cycle does not rescue the write; `note_ready` is derived from the pre-edge count.
- Pop: occurs only on a frame load. The head byte moves into a 8-bit shift register.
- Count update rule:
  - Push with pop in the same edge: `fifo_count` is unchanged.
  - Push only: +1.
  - Pop only: −1.
- Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `TxD`=1. If `fifo_count`≠0, load the head, pop, set `TxD`=0 and go to START.
  - START: hold `TxD`=0 for `CLKS_PER_BIT` cycles. Then `TxD`=shift[0], bit index=0, go to DATA.
  - DATA: hold each bit `CLKS_PER_BIT` cycles, then shift right and output the next bit. After bit 7 completes, `TxD`=1 and go to STOP.
  - STOP: hold `TxD`=1 for `CLKS_PER_BIT` cycles. Then:
    - if the FIFO is non-empty, load and pop the next byte, `TxD`=0, go directly to START (no idle gap);
    - otherwise go to IDLE.
- `busy`=1 in START, DATA and STOP; 0 in IDLE.
- The baud counter is 0..`CLKS_PER_BIT`−1. It restarts at 0 on every state or bit transition.
- A write during a frame never disturbs the frame in flight.

## Timing
- Latency: `note_valid` sampled at edge N into an empty FIFO in IDLE.
  - `fifo_count`=1 after N.
  - At N+1 the FSM loads; `TxD` falls and `busy` rises after edge N+1.
  - `fifo_count` returns to 0 after N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles: start, 8 data LSB-first, stop.
- Back-to-back frames have zero extra idle cycles between the stop bit and the next start bit.
- Sustained throughput is one byte per 10×`CLKS_PER_BIT` cycles.
- Reset mid-frame: outputs go to reset values immediately (asynchronously).
  - `TxD` goes high within the reset assertion; a truncated frame appears on the line.
  - FIFO contents are discarded.
- `overflow` is asserted in the cycle after the dropping edge, for one cycle per dropped byte.

## Test plan
- Use `CLKS_PER_BIT`=4 for all scenarios.
- Single byte: push 0x05 in IDLE.
  - `TxD` falls 2 edges after the push.
  - Sampling at bit centres gives 0,1,0,1,0,0,0,0,0,1.
  - `busy` is high for exactly 40 cycles; `fifo_count` goes 0→1→0.
- Back-to-back: push 0x02, 0x0B, 0x07 on consecutive cycles.
  - Three frames appear with no idle cycles between stop and start.
  - Decoded bytes are 0x02, 0x0B, 0x07; `busy` stays high for 120 cycles.
- Overflow: hold the FSM mid-frame and push 10 bytes with `FIFO_DEPTH`=8.
  - `note_ready` drops after the 8th write (count=8 held in the FIFO).
  - Two single-cycle `overflow` pulses occur.
  - The line carries the in-flight byte plus the 8 queued bytes, in order.
- Simultaneous push/pop: push a byte on the exact edge where STOP ends with count=1.
  - Count stays 1; the new byte is sent after the current next byte.
- Reset mid-DATA: assert `reset` during bit 3.
  - `TxD`=1, `busy`=0 and `fifo_count`=0 immediately.
  - After release, a push of 0x09 produces a clean frame.
- Wrap-around: push and drain 20 bytes, values 0x00–0x13.
  - All are transmitted in order across pointer wrap.
  - `fifo_count` never exceeds 8 and ends at 0.
